// File: rtl/fetchflare_arb_credit.sv
// Credit-tracked arbiter from the hardware prefetch engines onto one HPDcache requester port.
// The winner's tid is replaced by its engine index so that responses can be routed back to it.
package fetchflare_pkg;

    typedef logic [3:0] hpdcache_req_tid_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic [1:0]        op;
        logic [2:0]        size;
        hpdcache_req_tid_t tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic              error;
        hpdcache_req_tid_t tid;
    } hpdcache_rsp_t;

endpackage

module fetchflare_arb_credit
    import fetchflare_pkg::*;
#(
    parameter int unsigned  NUM_HW_PREFETCH = 4,
    parameter int unsigned  MAX_INFLIGHT    = 4,
    parameter int unsigned  ARB_MODE        = 0,
    localparam int unsigned CNT_W           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_HW_PREFETCH-1:0]         hwpf_enable_i,
    input  logic [NUM_HW_PREFETCH-1:0]         hwpf_req_valid_i,
    output logic [NUM_HW_PREFETCH-1:0]         hwpf_req_ready_o,
    input  hpdcache_req_t                      hwpf_req_i [NUM_HW_PREFETCH],
    output logic [NUM_HW_PREFETCH-1:0]         hwpf_rsp_valid_o,
    output hpdcache_rsp_t                      hwpf_rsp_o [NUM_HW_PREFETCH],
    output logic                               hpdcache_req_valid_o,
    input  logic                               hpdcache_req_ready_i,
    output hpdcache_req_t                      hpdcache_req_o,
    input  logic                               hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t                      hpdcache_rsp_i,
    output logic [NUM_HW_PREFETCH*CNT_W-1:0]   hwpf_inflight_o,
    output logic                               rsp_err_o
);

    localparam int unsigned       IDX_W   = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;
    localparam int unsigned       TID_W   = $bits(hpdcache_req_tid_t);
    localparam logic [TID_W:0]    NUM_ENG = (TID_W + 1)'(NUM_HW_PREFETCH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(NUM_HW_PREFETCH - 1);

    logic [CNT_W-1:0]           cnt_q [NUM_HW_PREFETCH];
    logic [IDX_W-1:0]           rr_ptr_q;
    logic                       slice_valid_q;
    hpdcache_req_t              slice_q;
    logic                       rsp_err_q;

    logic [NUM_HW_PREFETCH-1:0] eligible;
    logic [NUM_HW_PREFETCH-1:0] grant_oh;
    logic [NUM_HW_PREFETCH-1:0] cnt_inc;
    logic [NUM_HW_PREFETCH-1:0] cnt_dec;
    logic [NUM_HW_PREFETCH-1:0] rsp_hit;
    logic [IDX_W-1:0]           grant_idx;
    logic                       grant_any;
    logic                       load;
    logic                       accept;
    logic                       tid_oob;
    logic                       rsp_orphan;
    hpdcache_req_t              stamped;

    // An engine that already holds MAX_INFLIGHT credits is not allowed to compete.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
            eligible[i] = hwpf_req_valid_i[i] && hwpf_enable_i[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    // NOTE: every output of a combinational block gets a default on entry, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_HW_PREFETCH - 1; i >= 0; i--) begin
                if (eligible[IDX_W'(i)]) begin
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end else begin
            // Walk offsets downwards so the candidate closest to the pointer is written last.
            for (int k = NUM_HW_PREFETCH - 1; k >= 0; k--) begin
                int unsigned cand;
                cand = (32'(rr_ptr_q) + 32'(k)) % NUM_HW_PREFETCH;
                if (eligible[IDX_W'(cand)]) begin
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(cand);
                end
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign load             = !slice_valid_q || hpdcache_req_ready_i;
    assign accept           = grant_any && load;
    assign hwpf_req_ready_o = grant_oh & {NUM_HW_PREFETCH{load}};
    assign cnt_inc          = grant_oh & {NUM_HW_PREFETCH{accept}};

    always_comb begin
        stamped     = hwpf_req_i[grant_idx];
        stamped.tid = hpdcache_req_tid_t'(grant_idx);
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slice_valid_q <= 1'b0;
            slice_q       <= '0;
            rr_ptr_q      <= '0;
        end else begin
            if (accept) begin
                slice_valid_q <= 1'b1;
                slice_q       <= stamped;
                rr_ptr_q      <= (grant_idx == IDX_TOP) ? '0 : grant_idx + IDX_W'(1);
            end else if (hpdcache_req_ready_i) begin
                slice_valid_q <= 1'b0;
            end
        end
    end

    assign hpdcache_req_valid_o = slice_valid_q;
    assign hpdcache_req_o       = slice_q;

    // Responses are forwarded even when they are unexpected; only the error flag reports them.
    always_comb begin
        rsp_hit = '0;
        cnt_dec = '0;
        for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
            rsp_hit[i]    = hpdcache_rsp_valid_i && (hpdcache_rsp_i.tid == hpdcache_req_tid_t'(i));
            cnt_dec[i]    = rsp_hit[i] && (cnt_q[i] != '0);
            hwpf_rsp_o[i] = hpdcache_rsp_i;
        end
    end

    assign hwpf_rsp_valid_o = rsp_hit;
    assign tid_oob          = hpdcache_rsp_valid_i && ({1'b0, hpdcache_rsp_i.tid} >= NUM_ENG);
    assign rsp_orphan       = |(rsp_hit & ~cnt_dec);

    // NOTE: the credit array is control state, not storage, so every entry is reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
                cnt_q[i] <= '0;
            end
            rsp_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
                if (cnt_inc[i] && !cnt_dec[i] && (cnt_q[i] != CNT_MAX)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (cnt_dec[i] && !cnt_inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
            end
            rsp_err_q <= tid_oob || rsp_orphan;
        end
    end

    always_comb begin
        hwpf_inflight_o = '0;
        for (int i = 0; i < NUM_HW_PREFETCH; i++) begin
            hwpf_inflight_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign rsp_err_o = rsp_err_q;

    // Design invariants: a stalled slice holds still, at most one grant, credits bounded.
    a_slice_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (hpdcache_req_valid_o && !hpdcache_req_ready_i) |=>
        (hpdcache_req_valid_o && $stable(hpdcache_req_o)));

    a_grant_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(hwpf_req_ready_o));

    for (genvar gi = 0; gi < NUM_HW_PREFETCH; gi++) begin : g_cnt_chk
        a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
            cnt_q[gi] <= CNT_MAX);
    end

endmodule

// File: tb/tb_fetchflare_arb_credit.sv
// Bench for fetchflare_arb_credit: a round-robin and a fixed-priority instance share stimulus
// and are checked every cycle against a rule-level model plus directed literal expectations.
module tb_fetchflare_arb_credit;
    import fetchflare_pkg::*;

    localparam int N    = 4;
    localparam int MAXI = 2;
    localparam int CW   = $clog2(MAXI + 1);

    logic          clk;
    logic          rst_ni;
    logic [N-1:0]  en;
    logic [N-1:0]  req_valid;
    hpdcache_req_t req [N];
    logic          cache_ready;
    logic          rsp_valid_i;
    hpdcache_rsp_t rsp_i;

    logic [N-1:0]      rdy_rr, rdy_fp, rv_rr, rv_fp;
    hpdcache_rsp_t     ro_rr [N];
    hpdcache_rsp_t     ro_fp [N];
    logic              qv_rr, qv_fp;
    hpdcache_req_t     q_rr, q_fp;
    logic [N*CW-1:0]   inf_rr, inf_fp;
    logic              err_rr, err_fp;

    int vectors  = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    fetchflare_arb_credit #(.NUM_HW_PREFETCH(N), .MAX_INFLIGHT(MAXI), .ARB_MODE(0)) dut_rr (
        .clk_i(clk), .rst_ni(rst_ni), .hwpf_enable_i(en), .hwpf_req_valid_i(req_valid),
        .hwpf_req_ready_o(rdy_rr), .hwpf_req_i(req), .hwpf_rsp_valid_o(rv_rr), .hwpf_rsp_o(ro_rr),
        .hpdcache_req_valid_o(qv_rr), .hpdcache_req_ready_i(cache_ready), .hpdcache_req_o(q_rr),
        .hpdcache_rsp_valid_i(rsp_valid_i), .hpdcache_rsp_i(rsp_i), .hwpf_inflight_o(inf_rr),
        .rsp_err_o(err_rr));

    fetchflare_arb_credit #(.NUM_HW_PREFETCH(N), .MAX_INFLIGHT(MAXI), .ARB_MODE(1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni), .hwpf_enable_i(en), .hwpf_req_valid_i(req_valid),
        .hwpf_req_ready_o(rdy_fp), .hwpf_req_i(req), .hwpf_rsp_valid_o(rv_fp), .hwpf_rsp_o(ro_fp),
        .hpdcache_req_valid_o(qv_fp), .hpdcache_req_ready_i(cache_ready), .hpdcache_req_o(q_fp),
        .hpdcache_rsp_valid_i(rsp_valid_i), .hpdcache_rsp_i(rsp_i), .hwpf_inflight_o(inf_fp),
        .rsp_err_o(err_fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: index 0 = round-robin, 1 = fixed priority ----------
    logic          m_sv   [2];
    hpdcache_req_t m_sreq [2];
    int            m_cnt  [2][N];
    int            m_ptr  [2];
    logic          m_err  [2];

    function automatic int pick(input int d);
        int best = -1;
        for (int k = 0; k < N; k++) begin
            int i = (d == 0) ? (m_ptr[d] + k) % N : k;
            if (best < 0 && req_valid[i] && en[i] && m_cnt[d][i] < MAXI) best = i;
        end
        return best;
    endfunction

    task automatic model_step(input int d);
        int g;
        int t;
        int nc;
        logic acc;
        hpdcache_req_t r;
        g   = pick(d);
        acc = (g >= 0) && (!m_sv[d] || cache_ready);
        t   = int'(rsp_i.tid);
        if (rsp_valid_i) m_err[d] <= (t >= N) || (m_cnt[d][t % N] == 0);
        else             m_err[d] <= 1'b0;
        for (int i = 0; i < N; i++) begin
            nc = m_cnt[d][i];
            if (rsp_valid_i && t == i && nc > 0) nc--;
            if (acc && g == i) nc++;
            m_cnt[d][i] <= nc;
        end
        if (acc) begin
            r          = req[g];
            r.tid      = hpdcache_req_tid_t'(g);
            m_sreq[d] <= r;
            m_sv[d]   <= 1'b1;
            m_ptr[d]  <= (g + 1) % N;
        end else if (cache_ready) begin
            m_sv[d]   <= 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < 2; d++) begin
                m_sv[d]   <= 1'b0;
                m_sreq[d] <= '0;
                m_ptr[d]  <= 0;
                m_err[d]  <= 1'b0;
                for (int i = 0; i < N; i++) m_cnt[d][i] <= 0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic compare_dut(input int d, input logic [N-1:0] rdy, input logic [N-1:0] rv,
                               input hpdcache_rsp_t ro [N], input logic qv, input hpdcache_req_t q,
                               input logic [N*CW-1:0] inf, input logic err);
        string       p;
        int          g;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_rv;
        logic [N*CW-1:0] e_inf;
        p     = (d == 0) ? "rr" : "fp";
        g     = pick(d);
        e_rdy = '0;
        e_rv  = '0;
        e_inf = '0;
        if (g >= 0 && (!m_sv[d] || cache_ready)) e_rdy[g] = 1'b1;
        if (rsp_valid_i && int'(rsp_i.tid) < N) e_rv[rsp_i.tid] = 1'b1;
        for (int i = 0; i < N; i++) e_inf[i*CW +: CW] = CW'(m_cnt[d][i]);
        check({p, "_req_ready"}, 64'(rdy), 64'(e_rdy));
        check({p, "_rsp_valid"}, 64'(rv), 64'(e_rv));
        for (int i = 0; i < N; i++) check($sformatf("%s_rsp_data%0d", p, i), 64'(ro[i]), 64'(rsp_i));
        check({p, "_cache_valid"}, 64'(qv), 64'(m_sv[d]));
        check({p, "_cache_req"}, 64'(q), 64'(m_sreq[d]));
        check({p, "_inflight"}, 64'(inf), 64'(e_inf));
        check({p, "_rsp_err"}, 64'(err), 64'(m_err[d]));
    endtask

    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            compare_dut(0, rdy_rr, rv_rr, ro_rr, qv_rr, q_rr, inf_rr, err_rr);
            compare_dut(1, rdy_fp, rv_fp, ro_fp, qv_fp, q_fp, inf_fp, err_fp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        en          = '1;
        req_valid   = '0;
        cache_ready = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_i       = '0;
    endtask

    task automatic send_rsp(input int tid, input int data);
        rsp_valid_i = 1'b1;
        rsp_i.tid   = hpdcache_req_tid_t'(tid);
        rsp_i.rdata = 32'(data);
        rsp_i.error = data[0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    function automatic logic [CW-1:0] fld(input logic [N*CW-1:0] v, input int i);
        return v[i*CW +: CW];
    endfunction

    initial begin
        rst_ni = 1'b1;
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            req[i].addr = 32'h1000_0000 + 32'(i * 64);
            req[i].op   = 2'(i);
            req[i].size = 3'd3;
            req[i].tid  = 4'hC;
        end
        do_reset();
        cmp_en = 1'b1;
        #3;
        check("reset_cache_valid", 64'(qv_rr), 64'd0);
        check("reset_cache_req", 64'(q_rr), 64'd0);
        check("reset_inflight", 64'(inf_rr), 64'd0);
        check("reset_rsp_err", 64'(err_rr), 64'd0);

        // Round-robin streaming with responses three cycles after each accept.
        for (int c = 0; c < 12; c++) begin
            req_valid = '1;
            for (int i = 0; i < N; i++) req[i].addr = 32'h2000_0000 + 32'(c * 16 + i);
            if (c >= 3) send_rsp((c - 3) % N, 100 + c);
            else        rsp_valid_i = 1'b0;
            #3;
            if (c >= 1) begin
                check("t1_cache_valid", 64'(qv_rr), 64'd1);
                check("t1_issued_tid", 64'(q_rr.tid), 64'((c - 1) % N));
            end
            for (int i = 0; i < N; i++) check("t1_inflight_le1", 64'(fld(inf_rr, i) <= 1), 64'd1);
            @(negedge clk);
        end

        // Credit exhaustion on a single engine.
        do_reset();
        req_valid = 4'b0010;
        #3 check("t2_accept0", 64'(rdy_rr), 64'b0010);
        @(negedge clk); #3 check("t2_accept1", 64'(rdy_rr), 64'b0010);
        @(negedge clk); #3 check("t2_blocked", 64'(rdy_rr), 64'b0000);
        check("t2_cnt_full", 64'(fld(inf_rr, 1)), 64'd2);
        @(negedge clk); send_rsp(1, 7);
        #3 check("t2_still_blocked", 64'(rdy_rr), 64'b0000);
        check("t2_rsp_route", 64'(rv_rr), 64'b0010);
        @(negedge clk); rsp_valid_i = 1'b0;
        #3 check("t2_third_accept", 64'(rdy_rr), 64'b0010);
        check("t2_cnt_after_rsp", 64'(fld(inf_rr, 1)), 64'd1);

        // Output slice stall with engines 0 and 2 requesting.
        do_reset();
        req_valid   = 4'b0101;
        cache_ready = 1'b0;
        #3 check("t3_first_grant", 64'(rdy_rr), 64'b0001);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #3;
            check("t3_stall_tid", 64'(q_rr.tid), 64'd0);
            check("t3_stall_addr", 64'(q_rr.addr), 64'(req[0].addr));
            check("t3_no_accept", 64'(rdy_rr), 64'd0);
        end
        @(negedge clk); cache_ready = 1'b1;
        #3 check("t3_resume_grant", 64'(rdy_rr), 64'b0100);
        @(negedge clk); #3 check("t3_next_tid", 64'(q_rr.tid), 64'd2);

        // Accept and response for the same engine in one cycle.
        do_reset();
        req_valid = 4'b1000;
        #3 check("t4_grant3", 64'(rdy_rr), 64'b1000);
        @(negedge clk); send_rsp(3, 33);
        #3 check("t4_rsp_route", 64'(rv_rr), 64'b1000);
        check("t4_grant_again", 64'(rdy_rr), 64'b1000);
        @(negedge clk); idle_inputs();
        #3 check("t4_cnt_unchanged", 64'(fld(inf_rr, 3)), 64'd1);

        // Unexpected responses: tid out of range, then tid with no credit outstanding.
        do_reset();
        send_rsp(7, 70);
        #3 check("t5_oob_no_valid", 64'(rv_rr), 64'd0);
        @(negedge clk); send_rsp(2, 20);
        #3 check("t5_oob_err", 64'(err_rr), 64'd1);
        check("t5_orphan_route", 64'(rv_rr), 64'b0100);
        @(negedge clk); rsp_valid_i = 1'b0;
        #3 check("t5_orphan_err", 64'(err_rr), 64'd1);
        check("t5_cnt_stays0", 64'(fld(inf_rr, 2)), 64'd0);
        @(negedge clk); #3 check("t5_err_cleared", 64'(err_rr), 64'd0);

        // Fixed priority with a masked engine, then reset mid-stream.
        do_reset();
        req_valid = 4'b1010;
        en        = 4'b0111;
        #3 check("t6_fp_grant1", 64'(rdy_fp), 64'b0010);
        @(negedge clk); #3 check("t6_fp_grant1b", 64'(rdy_fp), 64'b0010);
        @(negedge clk); #3 check("t6_fp_masked", 64'(rdy_fp), 64'b0000);
        check("t6_fp_cnt1", 64'(fld(inf_fp, 1)), 64'd2);
        @(negedge clk); en = '1; req_valid = 4'b1110;
        #3 check("t6_fp_lowest", 64'(rdy_fp), 64'b0100);
        @(negedge clk); rst_ni = 1'b0;
        #3 check("t6_rst_valid", 64'(qv_fp), 64'd0);
        check("t6_rst_cnt", 64'(inf_fp), 64'd0);
        check("t6_rst_valid_rr", 64'(qv_rr), 64'd0);
        @(negedge clk); rst_ni = 1'b1; idle_inputs(); send_rsp(1, 11);
        @(negedge clk); rsp_valid_i = 1'b0;
        #3 check("t6_stale_rsp_err", 64'(err_fp), 64'd1);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
